blanking_mux: RTL
=================

BLANKING_MUX -- requirements
Module: blanking_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bits per data word.
REQ-002 SHALL have parameter N_INPUTS, default 3, meaning number of packed input words.
REQ-003 SHALL have parameter SEL_WIDTH, default 2, meaning width of one select code.
REQ-004 SHALL have parameter N_OUTPUTS, default 2, meaning number of independent output lanes.
REQ-005 SHALL have parameter BLANK_CYCLES, default 4, meaning output cycles blanked per switch; 0 is legal.
REQ-006 SHALL have parameter BLANK_MODE, default 0, meaning blanked output value: 0 = hold last dout, 1 = force zero.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-009 SHALL have port clken, input, 1, sel sampling enable.
REQ-010 SHALL have port din, input, N_INPUTS*WIDTH, packed inputs; word i is din[i*WIDTH +: WIDTH].
REQ-011 SHALL have port sel, input, N_OUTPUTS*SEL_WIDTH, requested select; lane k uses slice k.
REQ-012 SHALL have port err_clr, input, 1, clears every sel_err bit.
REQ-013 SHALL have port dout, output, N_OUTPUTS*WIDTH, registered lane outputs; lane k uses slice k.
REQ-014 SHALL have port dout_valid, output, N_OUTPUTS, lane k output is a settled selection.
REQ-015 SHALL have port sel_active, output, N_OUTPUTS*SEL_WIDTH, select currently applied per lane.
REQ-016 SHALL have port sel_err, output, N_OUTPUTS, sticky flag per lane for an out-of-range request.

Function
REQ-017 Lanes SHALL be fully independent, each with its own FSM (RUN, BLANK), down-counter, pending register and sel_active register.
REQ-018 sel is sampled only on edges with clken=1; when clken=0, sel SHALL have no effect.
REQ-019 Valid request: sel_k < N_INPUTS. An invalid request SHALL be ignored (no state change) and SHALL set sel_err[k] at that edge.
REQ-020 If err_clr=1 and a new error occur on the same edge, sel_err SHALL end set.
REQ-021 RUN, valid request equal to sel_active_k: no action and no blanking.
REQ-022 RUN, valid differing request, BLANK_CYCLES=0: sel_active_k SHALL load at that edge (E0); dout_k at E1 SHALL be the new input; dout_valid stays 1.
REQ-023 RUN, valid differing request, BLANK_CYCLES=B>0: at E0 the lane SHALL set pending=sel_k, counter=B-1, and enter BLANK.
REQ-024 In BLANK the counter SHALL decrement each edge. On the edge where counter==0, the lane SHALL set sel_active=pending and return to RUN.
REQ-025 Consequence of REQ-023/024: the dout updates at E1..EB are blanked with dout_valid=0, and E(B+1) SHALL carry din[new] with dout_valid=1.
REQ-026 A valid request during BLANK SHALL overwrite pending without restarting the counter, including a request equal to the old sel_active; the last request wins.
REQ-027 In RUN, dout_k SHALL register din[sel_active_k*WIDTH +: WIDTH] every edge, giving 1-cycle data latency.
REQ-028 In BLANK, dout_k SHALL hold its value (BLANK_MODE=0) or load zero (BLANK_MODE=1), and dout_valid_k SHALL be 0.
REQ-029 The din index SHALL never exceed N_INPUTS-1, because sel_active only ever holds validated codes.

Reset
REQ-030 While rst=1 at an edge, every lane SHALL be set to: state=RUN, sel_active=0, pending=0, counter=0, dout=0, dout_valid=0, sel_err=0.
REQ-031 rst SHALL override clken, sel and err_clr.
REQ-032 A reset asserted mid-BLANK SHALL abort the switch and discard pending.
REQ-033 On the first edge after rst deasserts, dout SHALL load din[0] and dout_valid SHALL become 1.

Verification
REQ-034 Reset then steady state: rst for 2 cycles, din={C,B,A}, clken=0 -> dout lane0 and lane1 both =A one edge after release, dout_valid=2'b11.
REQ-035 Blanked switch (B=4, mode 1): lane0 sel 0->2 at E0 -> dout lane0 =0 and valid=0 at E1..E4, =C at E5, sel_active=2 from E4; lane1 unaffected.
REQ-036 B=0 switch: sel 0->1 at E0 -> dout=B at E1, dout_valid never drops.
REQ-037 Retarget mid-blank (B=4, mode 0): request 1 at E0 and request 2 at E2 -> dout holds A through E4, C at E5, no extra blank cycles.
REQ-038 Invalid and clear: sel=3 (N_INPUTS=3) -> sel_err=1 and selection unchanged; err_clr with simultaneous invalid request -> sel_err stays 1; err_clr alone -> sel_err=0 next edge.
REQ-039 Reset during BLANK at E2 -> after release sel_active=0, dout=A, dout_valid=1, no residual blanking.

Source files
------------

// File: rtl/blanking_mux.sv
// Multi-lane registered word selector. Each lane blanks its output for a fixed
// number of cycles whenever its applied select code changes.
module blanking_mux #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned N_INPUTS     = 3,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned N_OUTPUTS    = 2,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLANK_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clken,
  input  logic [N_INPUTS*WIDTH-1:0]      din,
  input  logic [N_OUTPUTS*SEL_WIDTH-1:0] sel,
  input  logic                           err_clr,
  output logic [N_OUTPUTS*WIDTH-1:0]     dout,
  output logic [N_OUTPUTS-1:0]           dout_valid,
  output logic [N_OUTPUTS*SEL_WIDTH-1:0] sel_active,
  output logic [N_OUTPUTS-1:0]           sel_err
);

  localparam int unsigned N_CODES = 1 << SEL_WIDTH;
  localparam int unsigned CNT_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [SEL_WIDTH:0] N_IN_CODE = (SEL_WIDTH+1)'(N_INPUTS);
  localparam logic [CNT_W-1:0]   CNT_LOAD  =
    CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_BLANK} state_e;

  // Word table padded to every select code; padding is unreachable since
  // only validated codes are ever applied.
  logic [WIDTH-1:0] word [N_CODES];

  for (genvar i = 0; i < N_CODES; i++) begin : g_word
    if (i < N_INPUTS) begin : g_in
      assign word[i] = din[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign word[i] = '0;
    end
  end

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_lane
    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_k;
    logic [SEL_WIDTH-1:0] active_q, active_d;
    logic [SEL_WIDTH-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 in_range;
    logic                 req_ok;
    logic                 req_bad;

    assign sel_k    = sel[k*SEL_WIDTH +: SEL_WIDTH];
    assign in_range = ({1'b0, sel_k} < N_IN_CODE);
    assign req_ok   = clken && in_range;
    assign req_bad  = clken && !in_range;

    // Next-state: RUN tracks the applied word, BLANK counts down then applies pending.
    always_comb begin
      state_d  = state_q;
      active_d = active_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      err_d    = req_bad | (err_q & ~err_clr);
      case (state_q)
        ST_RUN: begin
          dout_d  = word[active_q];
          valid_d = 1'b1;
          if (req_ok && (sel_k != active_q)) begin
            if (BLANK_CYCLES == 0) begin
              active_d = sel_k;
            end else begin
              pend_d  = sel_k;
              cnt_d   = CNT_LOAD;
              state_d = ST_BLANK;
            end
          end
        end
        ST_BLANK: begin
          dout_d  = (BLANK_MODE != 0) ? '0 : dout_q;
          valid_d = 1'b0;
          if (req_ok) pend_d = sel_k;
          if (cnt_q == '0) begin
            active_d = pend_d;
            state_d  = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= ST_RUN;
        active_q <= '0;
        pend_q   <= '0;
        cnt_q    <= '0;
        dout_q   <= '0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        active_q <= active_d;
        pend_q   <= pend_d;
        cnt_q    <= cnt_d;
        dout_q   <= dout_d;
        valid_q  <= valid_d;
        err_q    <= err_d;
      end
    end

    assign dout[k*WIDTH +: WIDTH]             = dout_q;
    assign dout_valid[k]                      = valid_q;
    assign sel_active[k*SEL_WIDTH +: SEL_WIDTH] = active_q;
    assign sel_err[k]                         = err_q;
  end

endmodule
